// File: rtl/clk_div_delta_acc.sv
// Accumulates modular per-sample deltas of the sampled divider count and hands the sum to a host over valid/ready.
// Optional min/max delta tracking is enabled by defining CLK_DIV_MINMAX_EN.
module clk_div_delta_acc #(
    parameter int SIZE    = 8,
    parameter int NSAMP_W = 8,
    localparam int DW     = SIZE - 1,
    localparam int ACC_W  = DW + NSAMP_W
) (
    input  logic               clk_sample,
    input  logic               rst,
    input  logic [SIZE-1:0]    counter_in,
    input  logic               start,
    input  logic [NSAMP_W-1:0] n_samples,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ACC_W-1:0]   res_sum,
    output logic [DW-1:0]      res_min,
    output logic [DW-1:0]      res_max
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [NSAMP_W-1:0]   n_reg;
    logic [NSAMP_W-1:0]   count_reg;
    logic [DW-1:0]        prev_reg;
    logic [ACC_W-1:0]     sum_reg;
    logic                 res_valid_reg;
    logic [DW-1:0]        v;
    logic [DW-1:0]        delta;
    logic                 last_sample;
    logic                 handshake;
    logic                 unused_bit0;

    // Bit 0 is never driven by the upstream ripple divider.
    assign v           = counter_in[SIZE-1:1];
    assign unused_bit0 = counter_in[0];
    assign delta       = v - prev_reg;
    assign last_sample = (count_reg + NSAMP_W'(1)) == n_reg;
    assign handshake   = res_valid_reg && res_ready;

    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = PRIME;
            PRIME:   state_next = RUN;
            RUN:     if (last_sample) state_next = DONE;
            DONE:    if (handshake) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The sum is final on DONE entry; valid rises one edge later and drops after the transfer.
    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            n_reg         <= '0;
            count_reg     <= '0;
            prev_reg      <= '0;
            sum_reg       <= '0;
            res_valid_reg <= 1'b0;
        end else begin
            res_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        n_reg     <= (n_samples == '0) ? NSAMP_W'(1) : n_samples;
                        count_reg <= '0;
                        sum_reg   <= '0;
                    end
                end
                PRIME: prev_reg <= v;
                RUN: begin
                    sum_reg   <= sum_reg + ACC_W'(delta);
                    prev_reg  <= v;
                    count_reg <= count_reg + NSAMP_W'(1);
                end
                DONE: res_valid_reg <= !handshake;
                default: ;
            endcase
        end
    end

`ifdef CLK_DIV_MINMAX_EN
    logic [DW-1:0] min_reg;
    logic [DW-1:0] max_reg;

    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            min_reg <= '0;
            max_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            min_reg <= '1;
            max_reg <= '0;
        end else if (state_reg == RUN) begin
            if (delta < min_reg) min_reg <= delta;
            if (delta > max_reg) max_reg <= delta;
        end
    end

    assign res_min = min_reg;
    assign res_max = max_reg;
`else
    assign res_min = '0;
    assign res_max = '0;
`endif

    assign busy      = (state_reg != IDLE);
    assign res_valid = res_valid_reg;
    assign res_sum   = sum_reg;

endmodule

// File: tb/tb_clk_div_delta_acc.sv
// Directed bench for clk_div_delta_acc: hand-computed sums, wrap, stall/handshake, reset and n=0 cases.
module tb_clk_div_delta_acc;

    logic        clk_sample = 1'b0;
    logic        rst;
    logic [7:0]  counter_in;
    logic        start;
    logic [7:0]  n_samples;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [14:0] res_sum;
    logic [6:0]  res_min;
    logic [6:0]  res_max;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  seq [16];

`ifdef CLK_DIV_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    clk_div_delta_acc #(.SIZE(8), .NSAMP_W(8)) dut (
        .clk_sample (clk_sample),
        .rst        (rst),
        .counter_in (counter_in),
        .start      (start),
        .n_samples  (n_samples),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_min    (res_min),
        .res_max    (res_max)
    );

    always #5 clk_sample = ~clk_sample;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sample);
        #1;
    endtask

    // Accept start, feed nvals counter words (PRIME sample + one per RUN cycle), then expect valid one edge after DONE.
    task automatic measure(input string tag, input logic [7:0] nreq, input int nvals);
        start     = 1'b1;
        n_samples = nreq;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        for (int i = 0; i < nvals; i++) begin
            counter_in = seq[i];
            tick();
        end
        check({tag, "_valid_early"}, res_valid, 1'b0);
        tick();
        check({tag, "_valid"}, res_valid, 1'b1);
    endtask

    task automatic result(input string tag, input int sum, input int mn, input int mx);
        check({tag, "_sum"}, res_sum, sum);
        check({tag, "_min"}, res_min, MM ? mn : 0);
        check({tag, "_max"}, res_max, MM ? mx : 0);
        $display("%s: sum=%0d min=%0d max=%0d", tag, res_sum, res_min, res_max);
    endtask

    task automatic handshake(input string tag, input int sum);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_valid_drop"}, res_valid, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_sum_kept"}, res_sum, sum);
    endtask

    initial begin
        rst        = 1'b1;
        counter_in = 8'h00;
        start      = 1'b0;
        n_samples  = 8'd0;
        res_ready  = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_valid", res_valid, 1'b0);
        check("rst_sum", res_sum, 0);
        check("rst_min", res_min, 0);
        check("rst_max", res_max, 0);
        rst = 1'b0;
        tick();

        // T1: v = 8,11,14,17,20 -> four deltas of 3
        for (int i = 0; i < 5; i++) seq[i] = 8'(8'h10 + 6 * i);
        measure("t1", 8'd4, 5);
        result("t1", 12, 3, 3);
        handshake("t1", 12);

        // T2: v = 0x70,0x78,0x08,0x10 -> deltas 8,16,8 across the wrap
        seq[0] = 8'hE0; seq[1] = 8'hF0; seq[2] = 8'h10; seq[3] = 8'h20;
        measure("t2", 8'd3, 4);
        result("t2", 32, 8, 16);
        handshake("t2", 32);

        // T3: stopped clock, bit 0 toggling must not matter
        for (int i = 0; i < 11; i++) seq[i] = (i % 2 == 0) ? 8'h55 : 8'h54;
        measure("t3", 8'd10, 11);
        result("t3", 0, 0, 0);
        handshake("t3", 0);

        // T4: stall the consumer, pulse start, then start on the handshake cycle
        seq[0] = 8'h00; seq[1] = 8'h02; seq[2] = 8'h06;
        measure("t4", 8'd2, 3);
        result("t4", 3, 1, 2);
        for (int i = 0; i < 5; i++) begin
            start      = (i == 2);
            n_samples  = 8'd7;
            counter_in = 8'(8'h40 + 10 * i);
            tick();
            check("t4_hold_valid", res_valid, 1'b1);
            check("t4_hold_sum", res_sum, 3);
            check("t4_hold_busy", busy, 1'b1);
            check("t4_hold_min", res_min, MM ? 1 : 0);
        end
        start     = 1'b1;
        res_ready = 1'b1;
        tick();
        start     = 1'b0;
        res_ready = 1'b0;
        check("t4_hs_valid", res_valid, 1'b0);
        check("t4_hs_start_ignored", busy, 1'b0);
        tick();
        check("t4_still_idle", busy, 1'b0);
        $display("t4: stall and handshake-cycle start handled");

        // T5: reset in the middle of RUN clears outputs before the next edge
        start     = 1'b1;
        n_samples = 8'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            counter_in = 8'(2 * i);
            tick();
        end
        check("t5_run_sum", res_sum, 3);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_valid", res_valid, 1'b0);
        check("t5_rst_sum", res_sum, 0);
        tick();
        rst = 1'b0;
        tick();
        $display("t5: reset mid-run");

        // T6: n_samples=0 behaves as 1; v 8 -> 13 gives a single delta of 5
        seq[0] = 8'h10; seq[1] = 8'h1A;
        measure("t6", 8'd0, 2);
        result("t6", 5, 5, 5);
        handshake("t6", 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
